// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbiter state, read-return owner
// and the starvation counter width.
package dmem_arb_pkg;

  localparam int STARVE_W = 8;

  typedef enum logic {
    NORMAL,
    FORCE_D
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_C,
    OWN_D
  } rd_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles in which the debug port is denied and requests a
// single forced debug slot once the limit is reached.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_req,
  input  logic       d_gnt,
  input  arb_state_e state,
  output logic       force_next
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_MAX - 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // Any grant, idle debug port or forced cycle clears the run of denials.
  always_comb begin
    starve_d   = '0;
    force_next = 1'b0;
    if (state == NORMAL && d_req && !d_gnt) begin
      if (starve_q == LIMIT) begin
        force_next = 1'b1;
      end else begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core (C, fixed priority) and
// the debug master (D), with forced debug slots, read-return routing and a
// saturating conflict counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N          = 64,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [N-1:0]     c_addr,
  input  logic [N-1:0]     c_wdata,
  output logic             c_gnt,
  output logic             c_stall,
  output logic             c_rvalid,
  output logic [N-1:0]     c_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [N-1:0]     d_addr,
  input  logic [N-1:0]     d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [N-1:0]     d_rdata,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_writeData,
  output logic             mem_writeEnable,
  output logic             mem_readEnable,
  input  logic [N-1:0]     mem_readData,
  output logic [CNT_W-1:0] conflicts
);

  arb_state_e       state_q, state_d;
  rd_owner_e        rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0] conflicts_q, conflicts_d;
  logic             force_next;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .d_req     (d_req),
    .d_gnt     (d_gnt),
    .state     (state_q),
    .force_next(force_next)
  );

  // Grants come straight from the requests; nothing is granted during reset.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (state_q == FORCE_D) begin
        d_gnt = d_req;
        c_gnt = c_req & ~d_req;
      end else begin
        c_gnt = c_req;
        d_gnt = d_req & ~c_req;
      end
    end
  end

  assign c_stall = ~reset & c_req & ~c_gnt;

  always_comb begin
    mem_addr        = c_addr;
    mem_writeData   = c_wdata;
    mem_writeEnable = c_gnt & c_we;
    mem_readEnable  = c_gnt & ~c_we;
    if (d_gnt) begin
      mem_addr        = d_addr;
      mem_writeData   = d_wdata;
      mem_writeEnable = d_we;
      mem_readEnable  = ~d_we;
    end
  end

  // A forced slot lasts exactly one cycle whatever the requests do.
  always_comb begin
    state_d = NORMAL;
    if (state_q == NORMAL && force_next) begin
      state_d = FORCE_D;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (c_gnt && !c_we) begin
      rd_owner_d = OWN_C;
    end else if (d_gnt && !d_we) begin
      rd_owner_d = OWN_D;
    end
  end

  always_comb begin
    conflicts_d = conflicts_q;
    if (c_req && d_req && !(&conflicts_q)) begin
      conflicts_d = conflicts_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NORMAL;
      rd_owner_q  <= OWN_NONE;
      conflicts_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_owner_q  <= rd_owner_d;
      conflicts_q <= conflicts_d;
    end
  end

  // A read issued just before reset must not surface while reset is held.
  always_comb begin
    c_rvalid = ~reset & (rd_owner_q == OWN_C);
    d_rvalid = ~reset & (rd_owner_q == OWN_D);
    c_rdata  = c_rvalid ? mem_readData : '0;
    d_rdata  = d_rvalid ? mem_readData : '0;
  end

  assign conflicts = conflicts_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single data-memory port between the pipelined core (port C) and a debug/dump master (port D).
- Sits between datapath/dmem and the debug logic inside the processor top.
- Core has fixed priority, bounded by a starvation counter that forces one debug grant.
- Generates the core stall, routes 1-cycle-latency read data back to the correct owner, and counts conflicts.

Parameters:
- N, 64, data and address width.
- STARVE_MAX, 4, consecutive cycles port D may be denied before a forced grant (legal range 1..255).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  N  core byte address
- c_wdata  in  N  core write data
- c_gnt  out  1  core granted this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rvalid  out  1  core read data valid
- c_rdata  out  N  core read data
- d_req, d_we, d_addr[N], d_wdata[N]  in  debug request bundle, same meaning as port C
- d_gnt, d_rvalid  out  1 each; d_rdata  out  N
- mem_addr  out  N  to dmem address
- mem_writeData  out  N  to dmem writeData
- mem_writeEnable  out  1
- mem_readEnable  out  1
- mem_readData  in  N  from dmem, valid one cycle after mem_readEnable
- conflicts  out  CNT_W  saturating count of cycles with c_req & d_req both high

Behaviour:
- Grants are combinational from the request inputs and the registered state. At most one grant per cycle; c_gnt & d_gnt is never 1.
- State machine, 2 states:
  - NORMAL: c_req → port C wins. Else d_req → port D wins.
  - FORCE_D: d_req → port D wins; c_gnt=0 and c_stall=c_req. Else → port C wins if c_req.
  - Exit FORCE_D back to NORMAL after exactly one cycle, regardless of requests.
- Starvation counter `starve`, 8 bits:
  - In NORMAL, increments each cycle d_req=1 & d_gnt=0.
  - Clears on any d_gnt, or on a cycle where d_req=0.
  - When `starve` reaches STARVE_MAX-1 while denied → next state FORCE_D and `starve` clears.
  - With STARVE_MAX=4, port D is denied for 4 cycles and granted on the 5th.
- Memory drive:
  - The granted port's addr/wdata are muxed to mem_addr/mem_writeData.
  - mem_writeEnable = gnt & we.
  - mem_readEnable = gnt & ~we.
  - With no grant, both enables are 0, and mem_addr/mem_writeData hold port C values (no X).
  - A write commits at the clock edge ending the grant cycle; the write has zero extra latency.
- Read return:
  - Register `rd_owner` (none/C/D) is set at the edge ending a read grant.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_readData. The other port's rvalid=0 and its rdata=0.
  - Back-to-back reads by alternating owners return in grant order, one per cycle.
- Requester rule: hold req/we/addr/wdata stable until gnt. The arbiter does not latch requests; a dropped request is simply not serviced.
- conflicts: increments each cycle c_req & d_req = 1; saturates at all-ones.
- Reset, including mid-operation:
  - state=NORMAL, starve=0, rd_owner=none, conflicts=0.
  - While reset=1, all grants, enables and rvalids are 0; c_stall=0; rdata=0.
  - A read granted in the cycle before reset produces no rvalid after reset.
- Simultaneous FORCE_D entry and d_req drop: FORCE_D still lasts its one cycle, and port C is granted in it.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum {NORMAL, FORCE_D} for the arbiter state.
  - typedef enum {OWN_NONE, OWN_C, OWN_D} for rd_owner.
  - A localparam for the starve counter width (8).
- One natural sub-module: arb_starve_ctr. It implements the starvation counter and the FORCE_D request, with inputs d_req, d_gnt and state, and output force_next.
- Muxing and the read-return path stay in the top module.

Test Plan:
- Core-only: c_req=1, c_we=0, c_addr=0x10 for 1 cycle → c_gnt=1, mem_readEnable=1, mem_addr=0x10. Next cycle mem_readData=0xAB → c_rvalid=1, c_rdata=0xAB, d_rvalid=0.
- Debug-only write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55 → d_gnt=1, mem_writeEnable=1, c_stall=0, conflicts stays 0.
- Contention, STARVE_MAX=4: c_req and d_req held high 6 cycles →
  - c_gnt in cycles 0-3; d_gnt and c_stall=1 in cycle 4; c_gnt in cycle 5.
  - conflicts=6.
- Interleaved reads: C read at cycle 0, forced D read at cycle 1 → c_rvalid in cycle 1, d_rvalid in cycle 2, each carrying that cycle's mem_readData.
- Reset mid-read: C read granted in cycle 0, reset=1 in cycle 1 → c_rvalid=0 in cycles 1-2; starve and conflicts read 0 after reset.
- Saturation: CNT_W=4, both requests high 20 cycles → conflicts stops at 15.
